// File: rtl/clause_vote_scheduler.sv
// Inference sequencer for a convolutional Tsetlin machine: streams (class, clause) addresses,
// accumulates the in-order clause results into signed per-class votes and tracks the argmax.
module clause_vote_scheduler #(
  parameter int unsigned NUM_CLASSES     = 10,
  parameter int unsigned NUM_CLAUSES     = 512,
  parameter int unsigned CLASS_W         = 4,
  parameter int unsigned CLAUSE_W        = 9,
  parameter int unsigned SUM_W           = 11,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic [CLASS_W-1:0]  class_idx,
  output logic [CLAUSE_W-1:0] clause_idx,
  input  logic                res_valid,
  input  logic                res_clause,
  output logic                done,
  output logic [CLASS_W-1:0]  pred_class,
  output logic [SUM_W-1:0]    pred_sum
);

  localparam int unsigned OutW = 8;
  localparam logic [CLASS_W-1:0]  LastClass  = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CLAUSE_W-1:0] LastClause = CLAUSE_W'(NUM_CLAUSES - 1);
  localparam logic [OutW-1:0]     MaxOut     = OutW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [CLASS_W-1:0]        iss_class_q, iss_class_d, ret_class_q, ret_class_d;
  logic [CLAUSE_W-1:0]       iss_clause_q, iss_clause_d, ret_clause_q, ret_clause_d;
  logic [OutW-1:0]           out_q, out_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d, best_sum_q, best_sum_d, pred_sum_q, pred_sum_d;
  logic [CLASS_W-1:0]        best_cls_q, best_cls_d, pred_class_q, pred_class_d;
  logic                      xfer, res_acc, last_res;
  logic signed [SUM_W-1:0]   delta, final_sum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      iss_class_q  <= '0;
      iss_clause_q <= '0;
      ret_class_q  <= '0;
      ret_clause_q <= '0;
      out_q        <= '0;
      acc_q        <= '0;
      best_sum_q   <= '0;
      best_cls_q   <= '0;
      pred_sum_q   <= '0;
      pred_class_q <= '0;
    end else begin
      state_q      <= state_d;
      iss_class_q  <= iss_class_d;
      iss_clause_q <= iss_clause_d;
      ret_class_q  <= ret_class_d;
      ret_clause_q <= ret_clause_d;
      out_q        <= out_d;
      acc_q        <= acc_d;
      best_sum_q   <= best_sum_d;
      best_cls_q   <= best_cls_d;
      pred_sum_q   <= pred_sum_d;
      pred_class_q <= pred_class_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iss_class_d  = iss_class_q;
    iss_clause_d = iss_clause_q;
    ret_class_d  = ret_class_q;
    ret_clause_d = ret_clause_q;
    out_d        = out_q;
    acc_d        = acc_q;
    best_sum_d   = best_sum_q;
    best_cls_d   = best_cls_q;
    pred_sum_d   = pred_sum_q;
    pred_class_d = pred_class_q;

    busy       = (state_q == StRun) || (state_q == StDrain);
    done       = (state_q == StFinish);
    addr_valid = (state_q == StRun) && (out_q != MaxOut);
    class_idx  = iss_class_q;
    clause_idx = iss_clause_q;
    // Final result is visible through the done cycle, then held in pred_*_q.
    pred_class = done ? best_cls_q : pred_class_q;
    pred_sum   = done ? best_sum_q : pred_sum_q;

    xfer     = addr_valid && addr_ready;
    res_acc  = busy && res_valid && (out_q != '0);
    last_res = (ret_class_q == LastClass) && (ret_clause_q == LastClause);

    if (!res_clause)          delta = '0;
    else if (ret_clause_q[0]) delta = SUM_W'(1);
    else                      delta = '1;
    final_sum = acc_q + delta;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d      = StRun;
          iss_class_d  = '0;
          iss_clause_d = '0;
          ret_class_d  = '0;
          ret_clause_d = '0;
          out_d        = '0;
          acc_d        = '0;
          best_sum_d   = '0;
          best_cls_d   = '0;
          pred_sum_d   = '0;
          pred_class_d = '0;
        end
      end
      StRun, StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (xfer) begin
            if (iss_clause_q == LastClause) begin
              iss_clause_d = '0;
              if (iss_class_q == LastClass) begin
                iss_class_d = '0;
                state_d     = StDrain;
              end else begin
                iss_class_d = iss_class_q + CLASS_W'(1);
              end
            end else begin
              iss_clause_d = iss_clause_q + CLAUSE_W'(1);
            end
          end
          if (res_acc) begin
            if (ret_clause_q == LastClause) begin
              // Strict compare keeps the lower class index on ties.
              if ((ret_class_q == '0) || (final_sum > best_sum_q)) begin
                best_sum_d = final_sum;
                best_cls_d = ret_class_q;
              end
              acc_d        = '0;
              ret_clause_d = '0;
              ret_class_d  = (ret_class_q == LastClass) ? '0 : ret_class_q + CLASS_W'(1);
            end else begin
              acc_d        = final_sum;
              ret_clause_d = ret_clause_q + CLAUSE_W'(1);
            end
            if (last_res) state_d = StFinish;
          end
          out_d = out_q + OutW'(xfer) - OutW'(res_acc);
        end
      end
      StFinish: begin
        pred_sum_d   = best_sum_q;
        pred_class_d = best_cls_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_clause_vote_scheduler.sv
// Directed bench for clause_vote_scheduler: a small 3x4 instance for the protocol scenarios and
// a 10x512 instance checked against a vote model; an evaluator model answers 2 cycles after issue.
module tb_clause_vote_scheduler;

  typedef struct packed {logic [3:0] c; logic [8:0] k;} pair_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b0;
  logic s_start = 1'b0, b_start = 1'b0, abort = 1'b0, addr_ready = 1'b1;
  logic res_valid = 1'b0, res_clause = 1'b0;
  logic s_busy, s_addr_valid, s_done, b_busy, b_addr_valid, b_done;
  logic [3:0] s_class_idx, s_pred_class, b_class_idx, b_pred_class;
  logic [8:0] s_clause_idx, b_clause_idx;
  logic [10:0] s_pred_sum, b_pred_sum;

  logic busy, addr_valid, done;
  logic [3:0] class_idx, pred_class;
  logic [8:0] clause_idx;
  logic [10:0] pred_sum;

  bit sel = 1'b0;
  bit man = 1'b0, man_rv = 1'b0;
  int pat = 0;
  bit fire_tab [0:5119];
  logic s0v = 1'b0, s0f = 1'b0, s1v = 1'b0, s1f = 1'b0;
  pair_t log_q[$];
  int errors = 0, checks = 0;

  clause_vote_scheduler #(.NUM_CLASSES(3), .NUM_CLAUSES(4), .CLASS_W(4), .CLAUSE_W(9),
                          .SUM_W(11), .MAX_OUTSTANDING(2)) u_small (
    .clock(clock), .reset(reset), .start(s_start), .abort(abort), .busy(s_busy),
    .addr_valid(s_addr_valid), .addr_ready(addr_ready), .class_idx(s_class_idx),
    .clause_idx(s_clause_idx), .res_valid(res_valid), .res_clause(res_clause),
    .done(s_done), .pred_class(s_pred_class), .pred_sum(s_pred_sum)
  );

  clause_vote_scheduler #(.NUM_CLASSES(10), .NUM_CLAUSES(512), .CLASS_W(4), .CLAUSE_W(9),
                          .SUM_W(11), .MAX_OUTSTANDING(2)) u_big (
    .clock(clock), .reset(reset), .start(b_start), .abort(abort), .busy(b_busy),
    .addr_valid(b_addr_valid), .addr_ready(addr_ready), .class_idx(b_class_idx),
    .clause_idx(b_clause_idx), .res_valid(res_valid), .res_clause(res_clause),
    .done(b_done), .pred_class(b_pred_class), .pred_sum(b_pred_sum)
  );

  always_comb begin
    busy       = sel ? b_busy       : s_busy;
    addr_valid = sel ? b_addr_valid : s_addr_valid;
    done       = sel ? b_done       : s_done;
    class_idx  = sel ? b_class_idx  : s_class_idx;
    clause_idx = sel ? b_clause_idx : s_clause_idx;
    pred_class = sel ? b_pred_class : s_pred_class;
    pred_sum   = sel ? b_pred_sum   : s_pred_sum;
  end

  function automatic logic fire(input logic [3:0] c, input logic [8:0] k);
    case (pat)
      0:       return 1'b1;
      1:       return (c == 4'd2) ? k[0] : ((c < 4'd2) ? !k[0] : 1'b0);
      3:       return (c == 4'd0) ? 1'b1 : k[0];
      4:       return (c == 4'd1) ? (k == 9'd0) : !k[0];
      default: return fire_tab[int'(c) * 512 + int'(k)];
    endcase
  endfunction

  // Evaluator model: decides at the falling edge what the next rising edge will transfer.
  always @(negedge clock) begin
    if (addr_valid && addr_ready) log_q.push_back({class_idx, clause_idx});
    if (man) begin
      res_valid  <= man_rv;
      res_clause <= 1'b0;
      s0v        <= 1'b0;
      s1v        <= 1'b0;
    end else begin
      res_valid  <= s1v;
      res_clause <= s1f;
      s1v        <= s0v;
      s1f        <= s0f;
      s0v        <= addr_valid && addr_ready;
      s0f        <= fire(class_idx, clause_idx);
    end
  end

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_start();
    drive_edge();
    if (sel) b_start = 1'b1; else s_start = 1'b1;
    drive_edge();
    b_start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen, output bit prev_rv);
    seen    = 1'b0;
    prev_rv = 1'b0;
    for (int n = 0; n < limit; n++) begin
      sample();
      if (done) begin
        seen = 1'b1;
        break;
      end
      prev_rv = res_valid;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({s_busy, s_addr_valid, s_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/valid/done=%b required 000", {s_busy, s_addr_valid, s_done});
    end
    checks++;
    if (s_class_idx !== 4'd0 || s_clause_idx !== 9'd0 || s_pred_class !== 4'd0 ||
        s_pred_sum !== 11'd0) begin
      errors++;
      $display("FAIL reset_data: idx=%0d/%0d pred=%0d/%0d required all 0",
               s_class_idx, s_clause_idx, s_pred_class, s_pred_sum);
    end
    checks++;
    if ({b_busy, b_addr_valid, b_done} !== 3'b000 || b_pred_sum !== 11'd0) begin
      errors++;
      $display("FAIL reset_big: ctrl=%b sum=%0d required 000 0",
               {b_busy, b_addr_valid, b_done}, b_pred_sum);
    end
    drive_edge();
    reset = 1'b1;
    repeat (2) drive_edge();
  endtask

  task automatic test_all_fire();
    bit seen, prv;
    int bad;
    pat = 0;
    log_q.delete();
    pulse_start();
    sample();
    checks++;
    if ({busy, addr_valid} !== 2'b11 || class_idx !== 4'd0 || clause_idx !== 9'd0) begin
      errors++;
      $display("FAIL first_addr: busy/valid=%b idx=%0d/%0d required 11 0/0",
               {busy, addr_valid}, class_idx, clause_idx);
    end
    wait_done(200, seen, prv);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL all_fire_done: seen=%b required 1", seen);
    end
    checks++;
    if (prv !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: prev res_valid=%b busy=%b required 1 0", prv, busy);
    end
    checks++;
    if (pred_class !== 4'd0 || pred_sum !== 11'd0) begin
      errors++;
      $display("FAIL all_fire_pred: got %0d/%0d required 0/0", pred_class, pred_sum);
    end
    bad = 0;
    for (int i = 0; i < log_q.size() && i < 12; i++)
      if (log_q[i] !== {4'(i / 4), 9'(i % 4)}) bad++;
    checks++;
    if (log_q.size() != 12 || bad != 0) begin
      errors++;
      $display("FAIL issue_order: count=%0d bad=%0d required 12 0", log_q.size(), bad);
    end
    sample();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b one cycle later required 0", done);
    end
    repeat (4) drive_edge();
  endtask

  task automatic test_stall();
    bit seen, prv, seen_v;
    int bad, n;
    pair_t cap;
    pat = 0;
    log_q.delete();
    pulse_start();
    n = 0;
    while (log_q.size() < 5 && n < 100) begin
      drive_edge();
      n++;
    end
    addr_ready = 1'b0;
    seen_v = 1'b0;
    bad = 0;
    cap = '0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (seen_v) begin
        if (addr_valid !== 1'b1 || {class_idx, clause_idx} !== cap) bad++;
      end else if (addr_valid) begin
        seen_v = 1'b1;
        cap = {class_idx, clause_idx};
      end
    end
    checks++;
    if (seen_v !== 1'b1 || bad != 0 || cap !== {4'd1, 9'd1}) begin
      errors++;
      $display("FAIL stall_hold: valid_seen=%b unstable=%0d held=%0d/%0d required 1 0 1/1",
               seen_v, bad, cap.c, cap.k);
    end
    drive_edge();
    addr_ready = 1'b1;
    wait_done(200, seen, prv);
    bad = 0;
    for (int i = 0; i < log_q.size() && i < 12; i++)
      if (log_q[i] !== {4'(i / 4), 9'(i % 4)}) bad++;
    checks++;
    if (seen !== 1'b1 || log_q.size() != 12 || bad != 0) begin
      errors++;
      $display("FAIL stall_order: done=%b count=%0d bad=%0d required 1 12 0",
               seen, log_q.size(), bad);
    end
    repeat (4) drive_edge();
  endtask

  task automatic test_polarity();
    int pats [3] = '{1, 3, 4};
    logic [3:0] exp_c [3] = '{4'd2, 4'd1, 4'd1};
    logic [10:0] exp_s [3] = '{11'd2, 11'd2, 11'h7ff};
    bit seen, prv;
    for (int t = 0; t < 3; t++) begin
      pat = pats[t];
      pulse_start();
      wait_done(200, seen, prv);
      checks++;
      if (seen !== 1'b1 || pred_class !== exp_c[t] || pred_sum !== exp_s[t]) begin
        errors++;
        $display("FAIL vote_pat%0d: done=%b pred=%0d sum=%h required 1 %0d %h",
                 pats[t], seen, pred_class, pred_sum, exp_c[t], exp_s[t]);
      end
      repeat (3) sample();
      checks++;
      if (pred_class !== exp_c[t] || pred_sum !== exp_s[t]) begin
        errors++;
        $display("FAIL pred_hold_pat%0d: pred=%0d sum=%h required %0d %h",
                 pats[t], pred_class, pred_sum, exp_c[t], exp_s[t]);
      end
    end
    pat = 1;
    pulse_start();
    wait_done(200, seen, prv);
    repeat (4) drive_edge();
  endtask

  task automatic test_back_to_back();
    pat = 0;
    man = 1'b1;
    man_rv = 1'b0;
    log_q.delete();
    pulse_start();
    sample();
    checks++;
    if (pred_class !== 4'd0 || pred_sum !== 11'd0) begin
      errors++;
      $display("FAIL pred_clear: pred=%0d sum=%0d required 0 0", pred_class, pred_sum);
    end
    repeat (6) sample();
    checks++;
    if (log_q.size() != 2 || addr_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL outstanding_cap: transfers=%0d valid=%b busy=%b required 2 0 1",
               log_q.size(), addr_valid, busy);
    end
    drive_edge();
    man_rv = 1'b1;
    drive_edge();
    sample();
    checks++;
    if (addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL one_returned: valid=%b required 1", addr_valid);
    end
    drive_edge();
    man_rv = 1'b0;
    sample();
    checks++;
    if (addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL coincident: valid=%b required 1", addr_valid);
    end
    drive_edge();
    sample();
    checks++;
    if (addr_valid !== 1'b0 || log_q.size() != 4 || log_q[log_q.size()-1] !== {4'd0, 9'd3}) begin
      errors++;
      $display("FAIL refill_cap: valid=%b transfers=%0d required 0 4", addr_valid, log_q.size());
    end
    drive_edge();
    abort = 1'b1;
    drive_edge();
    abort = 1'b0;
    sample();
    checks++;
    if ({busy, addr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_drain: busy/valid=%b required 00", {busy, addr_valid});
    end
    man = 1'b0;
    repeat (4) drive_edge();
  endtask

  task automatic test_abort();
    bit seen, prv, any_done, any_valid;
    int n, sz;
    pat = 0;
    log_q.delete();
    pulse_start();
    n = 0;
    while (log_q.size() < 5 && n < 100) begin
      drive_edge();
      n++;
    end
    abort = 1'b1;
    drive_edge();
    abort = 1'b0;
    sz = log_q.size();
    sample();
    checks++;
    if ({busy, addr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_busy: busy/valid=%b required 00", {busy, addr_valid});
    end
    any_done = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      any_done |= done;
      any_valid |= addr_valid | busy;
    end
    checks++;
    if (any_done || any_valid || log_q.size() != sz) begin
      errors++;
      $display("FAIL abort_quiet: done=%b active=%b transfers=%0d required 0 0 %0d",
               any_done, any_valid, log_q.size(), sz);
    end
    pat = 1;
    pulse_start();
    wait_done(200, seen, prv);
    checks++;
    if (seen !== 1'b1 || pred_class !== 4'd2 || pred_sum !== 11'd2) begin
      errors++;
      $display("FAIL rerun_after_abort: done=%b pred=%0d sum=%0d required 1 2 2",
               seen, pred_class, pred_sum);
    end
    repeat (4) drive_edge();
  endtask

  task automatic test_reset_drain_golden();
    int sums [10];
    int best, n;
    bit seen, prv;
    logic [10:0] exp_s;
    sel = 1'b1;
    pat = 2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5120; i++) fire_tab[i] = 1'($urandom_range(0, 1));
      for (int c = 0; c < 10; c++) begin
        sums[c] = 0;
        for (int k = 0; k < 512; k++)
          if (fire_tab[c * 512 + k]) sums[c] += (k % 2 == 1) ? 1 : -1;
      end
      best = 0;
      for (int c = 1; c < 10; c++) if (sums[c] > sums[best]) best = c;
      exp_s = 11'(sums[best]);
      if (r == 1) begin
        log_q.delete();
        pulse_start();
        n = 0;
        while (log_q.size() < 5120 && n < 20000) begin
          drive_edge();
          n++;
        end
        checks++;
        if (busy !== 1'b1 || addr_valid !== 1'b0 || log_q.size() != 5120) begin
          errors++;
          $display("FAIL reach_drain: busy=%b valid=%b transfers=%0d required 1 0 5120",
                   busy, addr_valid, log_q.size());
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, addr_valid, done} !== 3'b000 || class_idx !== 4'd0 ||
            clause_idx !== 9'd0 || pred_class !== 4'd0 || pred_sum !== 11'd0) begin
          errors++;
          $display("FAIL reset_in_drain: ctrl=%b idx=%0d/%0d pred=%0d/%0d required all 0",
                   {busy, addr_valid, done}, class_idx, clause_idx, pred_class, pred_sum);
        end
        drive_edge();
        reset = 1'b1;
        repeat (6) drive_edge();
        checks++;
        if ({busy, done} !== 2'b00 || pred_sum !== 11'd0) begin
          errors++;
          $display("FAIL late_results: busy/done=%b sum=%0d required 00 0",
                   {busy, done}, pred_sum);
        end
      end
      pulse_start();
      wait_done(20000, seen, prv);
      checks++;
      if (seen !== 1'b1 || pred_class !== 4'(best) || pred_sum !== exp_s) begin
        errors++;
        $display("FAIL golden_run%0d: done=%b pred=%0d sum=%h required 1 %0d %h",
                 r, seen, pred_class, pred_sum, best, exp_s);
      end
      repeat (4) drive_edge();
    end
    sel = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_fire();
    test_stall();
    test_polarity();
    test_back_to_back();
    test_abort();
    test_reset_drain_golden();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
